// File: rtl/pc_ras_unit.sv
// pc_ras_unit: program counter with in-block next-PC select and a circular return-address stack.
// Define PC_ALIGN_CHECK_EN to reject branch/call targets whose low two bits are non-zero.
module pc_ras_unit #(
   parameter int unsigned     PC_W      = 32,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter int unsigned     INC       = 4,
   parameter int unsigned     RAS_DEPTH = 4
) (
   input  logic                               i_clk,
   input  logic                               i_rst_n,
   input  logic                               i_pc_w_c,
   input  logic [1:0]                         i_sel,
   input  logic [PC_W-1:0]                    i_target,
   output logic [PC_W-1:0]                    o_pc,
   output logic [PC_W-1:0]                    o_ras_top,
   output logic [$clog2(RAS_DEPTH+1)-1:0]     o_ras_cnt,
   output logic                               o_ras_empty,
   output logic                               o_ras_full,
   output logic                               o_ras_err,
   output logic                               o_align_err
);

   localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
   localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

   localparam logic [1:0] SEL_SEQ    = 2'b00;
   localparam logic [1:0] SEL_BRANCH = 2'b01;
   localparam logic [1:0] SEL_CALL   = 2'b10;
   localparam logic [1:0] SEL_RET    = 2'b11;

   logic [PC_W-1:0]  pc_q, pc_d, pc_inc_c;
   logic [PC_W-1:0]  ras_q [RAS_DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc_c, ptr_dec_c;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ras_err_q, ras_err_d;
   logic             push_c;
   logic             empty_c, full_c;
   logic             load_ok_c;

   assign pc_inc_c  = pc_q + PC_W'(INC);
   assign empty_c   = (cnt_q == '0);
   assign full_c    = (cnt_q == CNT_W'(RAS_DEPTH));
   assign ptr_inc_c = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
   assign ptr_dec_c = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);

`ifdef PC_ALIGN_CHECK_EN
   logic align_err_q, align_err_d;

   assign load_ok_c = (i_target[1:0] == 2'b00);

   // Misaligned branch/call targets latch the sticky alignment flag.
   always_comb begin
      align_err_d = align_err_q;
      if (i_pc_w_c && ((i_sel == SEL_BRANCH) || (i_sel == SEL_CALL)) && !load_ok_c)
         align_err_d = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) align_err_q <= 1'b0;
      else          align_err_q <= align_err_d;
   end

   assign o_align_err = align_err_q;
`else
   assign load_ok_c   = 1'b1;
   assign o_align_err = 1'b0;
`endif

   // Next-PC and RAS pointer/count update.
   always_comb begin
      pc_d      = pc_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      ras_err_d = ras_err_q;
      push_c    = 1'b0;
      if (i_pc_w_c) begin
         case (i_sel)
            SEL_SEQ: pc_d = pc_inc_c;
            SEL_BRANCH: begin
               if (load_ok_c) pc_d = i_target;
            end
            SEL_CALL: begin
               if (load_ok_c) begin
                  pc_d   = i_target;
                  push_c = 1'b1;
                  ptr_d  = ptr_inc_c;
                  // A full stack overwrites its oldest slot, which is the one after top.
                  if (full_c) ras_err_d = 1'b1;
                  else        cnt_d     = cnt_q + CNT_W'(1);
               end
            end
            SEL_RET: begin
               if (empty_c) begin
                  pc_d      = pc_inc_c;
                  ras_err_d = 1'b1;
               end else begin
                  pc_d  = ras_q[ptr_q];
                  ptr_d = ptr_dec_c;
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: pc_d = pc_q;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc_q      <= RESET_PC;
         ptr_q     <= '0;
         cnt_q     <= '0;
         ras_err_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         ras_err_q <= ras_err_d;
      end
   end

   // Return-address storage; the return address is taken from the pre-edge PC.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
      end else if (push_c) begin
         ras_q[ptr_d] <= pc_inc_c;
      end
   end

   assign o_pc        = pc_q;
   assign o_ras_top   = empty_c ? '0 : ras_q[ptr_q];
   assign o_ras_cnt   = cnt_q;
   assign o_ras_empty = empty_c;
   assign o_ras_full  = full_c;
   assign o_ras_err   = ras_err_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Scoreboard bench for pc_ras_unit: directed writes queue hand-computed expectations,
// a monitor pops and compares one expectation after each rising edge.
module tb_pc_ras_unit;

   localparam int unsigned PC_W  = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   localparam logic [1:0] SEQ = 2'b00;
   localparam logic [1:0] BR  = 2'b01;
   localparam logic [1:0] CAL = 2'b10;
   localparam logic [1:0] RET = 2'b11;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             we;
   logic [1:0]       sel;
   logic [PC_W-1:0]  target;
   logic [PC_W-1:0]  pc, ras_top;
   logic [CNT_W-1:0] ras_cnt;
   logic             ras_empty, ras_full, ras_err, align_err;

   typedef struct {
      int          id;
      logic [31:0] pc;
      logic [31:0] cnt;
      logic [31:0] top;
      logic        err;
      logic        aerr;
   } exp_t;

   exp_t scb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   step_id  = 0;

   pc_ras_unit #(
      .PC_W(PC_W), .RESET_PC('0), .INC(4), .RAS_DEPTH(DEPTH)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_pc_w_c(we), .i_sel(sel), .i_target(target),
      .o_pc(pc), .o_ras_top(ras_top), .o_ras_cnt(ras_cnt), .o_ras_empty(ras_empty),
      .o_ras_full(ras_full), .o_ras_err(ras_err), .o_align_err(align_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and queue the post-edge expectation.
   task automatic step(input logic w, input logic [1:0] s, input logic [31:0] t,
                       input logic [31:0] e_pc, input logic [31:0] e_cnt,
                       input logic [31:0] e_top, input logic e_err, input logic e_aerr);
      exp_t e;
      @(negedge clk);
      we = w; sel = s; target = t;
      step_id++;
      e.id = step_id; e.pc = e_pc; e.cnt = e_cnt; e.top = e_top; e.err = e_err; e.aerr = e_aerr;
      scb.push_back(e);
   endtask

   // Mid-cycle reset with a write in flight; the edge during reset must not advance the PC.
   task automatic do_reset(input string tag);
      @(negedge clk);
      we = 1'b1; sel = SEQ; target = 32'h0;
      #2 rst_n = 1'b0;
      #1;
      check({tag, " pc async"}, pc, 32'h0);
      check({tag, " cnt"}, 32'(ras_cnt), 32'h0);
      check({tag, " top"}, ras_top, 32'h0);
      check({tag, " empty"}, 32'(ras_empty), 32'h1);
      check({tag, " err"}, 32'(ras_err), 32'h0);
      check({tag, " aerr"}, 32'(align_err), 32'h0);
      @(posedge clk); #1;
      check({tag, " pc held in reset"}, pc, 32'h0);
      @(negedge clk);
      we = 1'b0;
      rst_n = 1'b1;
   endtask

   // Monitor: compare the oldest queued expectation after every rising edge.
   initial begin
      exp_t  e;
      string n;
      forever begin
         @(posedge clk); #1;
         if (scb.size() > 0) begin
            e = scb.pop_front();
            n = $sformatf("step%0d", e.id);
            check({n, " pc"}, pc, e.pc);
            check({n, " cnt"}, 32'(ras_cnt), e.cnt);
            check({n, " top"}, ras_top, e.top);
            check({n, " empty"}, 32'(ras_empty), 32'(e.cnt == 0));
            check({n, " full"}, 32'(ras_full), 32'(e.cnt == DEPTH));
            check({n, " ras_err"}, 32'(ras_err), 32'(e.err));
            check({n, " align_err"}, 32'(align_err), 32'(e.aerr));
         end
      end
   end

   initial begin
      int budget;
      rst_n = 1'b0; we = 1'b0; sel = SEQ; target = '0;
      #3 check("initial reset pc", pc, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      step(1, SEQ, 0, 32'h4, 0, 0, 0, 0);
      step(1, SEQ, 0, 32'h8, 0, 0, 0, 0);

      // Reset mid-operation, then sequential from RESET_PC.
      do_reset("rst1");
      step(1, SEQ, 0, 32'h4, 0, 0, 0, 0);
      step(1, SEQ, 0, 32'h8, 0, 0, 0, 0);
      step(1, SEQ, 0, 32'hC, 0, 0, 0, 0);

      // Hold while write enable is low.
      step(1, BR, 32'h40, 32'h40, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, BR, 32'h100, 32'h40, 0, 0, 0, 0);

      // Call / return.
      step(1, BR,  32'h10,  32'h10,  0, 0,     0, 0);
      step(1, CAL, 32'h200, 32'h200, 1, 32'h14, 0, 0);
      step(1, RET, 32'h0,   32'h14,  0, 0,     0, 0);

      // Overflow: five calls into a four-deep stack, then drain.
      step(1, BR,  32'h0,   32'h0,   0, 0,      0, 0);
      step(1, CAL, 32'h100, 32'h100, 1, 32'h4,   0, 0);
      step(1, CAL, 32'h200, 32'h200, 2, 32'h104, 0, 0);
      step(1, CAL, 32'h300, 32'h300, 3, 32'h204, 0, 0);
      step(1, CAL, 32'h400, 32'h400, 4, 32'h304, 0, 0);
      step(1, CAL, 32'h500, 32'h500, 4, 32'h404, 1, 0);
      step(1, RET, 32'h0,   32'h404, 3, 32'h304, 1, 0);
      step(1, RET, 32'h0,   32'h304, 2, 32'h204, 1, 0);
      step(1, RET, 32'h0,   32'h204, 1, 32'h104, 1, 0);
      step(1, RET, 32'h0,   32'h104, 0, 0,      1, 0);

      // Underflow with PC wrap.
      do_reset("rst2");
      step(1, BR,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 0, 0);
      step(1, RET, 32'h0,         32'h0,         0, 0, 1, 0);
      step(0, RET, 32'h0,         32'h0,         0, 0, 1, 0);

      // Target alignment.
      step(1, BR, 32'h20, 32'h20, 0, 0, 1, 0);
`ifdef PC_ALIGN_CHECK_EN
      step(1, BR,  32'h102, 32'h20,  0, 0, 1, 1);
      step(1, BR,  32'h104, 32'h104, 0, 0, 1, 1);
      step(1, CAL, 32'h203, 32'h104, 0, 0, 1, 1);
      step(1, RET, 32'h0,   32'h108, 0, 0, 1, 1);
`else
      step(1, BR,  32'h102, 32'h102, 0, 0,      1, 0);
      step(1, BR,  32'h104, 32'h104, 0, 0,      1, 0);
      step(1, CAL, 32'h203, 32'h203, 1, 32'h108, 1, 0);
      step(1, RET, 32'h0,   32'h108, 0, 0,      1, 0);
`endif

      @(negedge clk);
      we = 1'b0;
      budget = 20;
      while (scb.size() > 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      n_checks++;
      if (scb.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", scb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised program-counter unit for the multicycle CPU. Generalises the plain 32-bit PC register in three ways: width and reset vector are parameters; next-PC selection is done inside the block; a return-address stack (RAS) supports call/return.
- Sits between the control FSM and the instruction-memory address path.
- Controlled by a write strobe and a 2-bit select from the control unit.

Parameters:
- PC_W, 32, PC and target width in bits.
- RESET_PC, 0, o_pc value on reset.
- INC, 4, sequential increment, added modulo 2^PC_W.
- RAS_DEPTH, 4, number of RAS entries (>=2).

Ports:
- i_clk, input, 1, clock; rising-edge active.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_pc_w_c, input, 1, PC write enable; no state changes when 0.
- i_sel, input, 2, next-PC select: 00 seq, 01 branch, 10 call, 11 return.
- i_target, input, PC_W, branch/call target.
- o_pc, output, PC_W, current PC (registered).
- o_ras_top, output, PC_W, top RAS entry; 0 when empty.
- o_ras_cnt, output, clog2(RAS_DEPTH+1), number of valid entries.
- o_ras_empty, output, 1, o_ras_cnt==0.
- o_ras_full, output, 1, o_ras_cnt==RAS_DEPTH.
- o_ras_err, output, 1, sticky underflow/overflow flag.
- o_align_err, output, 1, sticky misaligned-target flag; see Optional Feature.

Behaviour:
- Reset (asynchronous, on falling i_rst_n, held while low):
  - o_pc=RESET_PC.
  - RAS count=0, all entries=0.
  - o_ras_err=0, o_align_err=0.
- Clocking: every update happens on the rising i_clk edge, and only when i_pc_w_c=1. There is no latency beyond one clock: the new o_pc is visible after the edge.
- When i_pc_w_c=0, o_pc, the RAS and both flags hold, whatever i_sel is.
- seq (00): o_pc <= o_pc+INC. The sum wraps: all-ones+INC truncates to PC_W bits.
- branch (01): o_pc <= i_target. RAS unchanged.
- call (10):
  - o_pc <= i_target.
  - Push o_pc+INC (the return address, computed from the pre-edge PC).
  - If the RAS is not full, count increments.
  - If full: the push is circular. The oldest entry is discarded, the new entry becomes top, count stays RAS_DEPTH, and o_ras_err is set.
- return (11):
  - If not empty: o_pc <= o_ras_top, pop, count decrements.
  - If empty: o_pc <= o_pc+INC (falls through as seq), RAS unchanged, o_ras_err is set.
- RAS implementation: circular buffer with a top pointer and a count. o_ras_top, o_ras_cnt, o_ras_empty and o_ras_full are combinational from registered state.
- Sticky flags: once set, o_ras_err and o_align_err are cleared only by reset.
- Reset asserted mid-operation overrides any in-flight write. The first write after release uses RESET_PC as the current PC.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Applies to branch/call whenever i_target[1:0]!=0.
  - The load is suppressed and o_pc holds.
  - On a call, no push happens.
  - o_align_err is set.
  - Seq and return are never checked.
- Undefined:
  - Targets load verbatim.
  - o_align_err is tied to 0.
  - No check logic is generated.

Test Plan:
- Reset/seq: assert i_rst_n=0 mid-cycle -> o_pc=0 immediately. Release, then 3 cycles of i_pc_w_c=1, i_sel=00 -> o_pc 4, 8, 0xC.
- Hold: set o_pc=0x40, then i_pc_w_c=0 with i_sel=01, i_target=0x100 for 5 cycles -> o_pc stays 0x40, o_ras_cnt stays 0.
- Call/return: from o_pc=0x10, call 0x200 -> o_pc=0x200, o_ras_top=0x14, cnt=1. Then return -> o_pc=0x14, cnt=0, o_ras_empty=1.
- Overflow (RAS_DEPTH=4): 5 calls from PCs 0x0, 0x100, 0x200, 0x300, 0x400 -> cnt=4, o_ras_err=1. Then 4 returns -> o_pc sequence 0x404, 0x304, 0x204, 0x104; entry 0x4 was lost.
- Underflow/wrap: return with empty RAS at o_pc=0xFFFF_FFFC -> o_pc=0x0 (wrap), o_ras_err=1, cnt=0.
- Align (macro defined): branch to 0x102 from o_pc=0x20 -> o_pc stays 0x20, o_align_err=1. Then branch to 0x104 -> o_pc=0x104 while o_align_err stays 1. With the macro undefined, the same branch to 0x102 gives o_pc=0x102 and o_align_err=0.
